// File: rtl/window_sum_pkg.sv
// window_sum_pkg: shared constants and helpers for the sliding-window summer.
//   clog2()  - ceiling log2, constant-foldable, used for counter and sum widths.
//   sum_w()  - output width that holds WINDOW full-scale samples without overflow.
//   DefDataW / DefWindow / DefSumW - default parameterisation.
package window_sum_pkg;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        while ((longint'(1) << result) < longint'(value)) begin
            result++;
        end
        return result;
    endfunction

    function automatic int unsigned sum_w(input int unsigned data_w, input int unsigned window);
        return data_w + clog2(window);
    endfunction

    localparam int unsigned DefDataW  = 8;
    localparam int unsigned DefWindow = 3;
    localparam int unsigned DefSumW   = sum_w(DefDataW, DefWindow);

endpackage

// File: rtl/window_sum_if.sv
// window_sum_if: sample-in / sum-out bundle for window_sum.
//   clear     - synchronous restart of the window fill (master -> slave)
//   in_valid  - d carries a sample this cycle          (master -> slave)
//   d         - unsigned sample, DATA_W bits            (master -> slave)
//   out_valid - sum_out holds a new complete-window sum (slave -> master)
//   sum_out   - registered window sum, SUM_W bits       (slave -> master)
interface window_sum_if
    import window_sum_pkg::*;
#(
    parameter int unsigned DATA_W = DefDataW,
    parameter int unsigned SUM_W  = DefSumW
);
    logic              clear;
    logic              in_valid;
    logic [DATA_W-1:0] d;
    logic              out_valid;
    logic [SUM_W-1:0]  sum_out;

    modport master (
        output clear,
        output in_valid,
        output d,
        input  out_valid,
        input  sum_out
    );

    modport slave (
        input  clear,
        input  in_valid,
        input  d,
        output out_valid,
        output sum_out
    );
endinterface

// File: rtl/window_sum_lane.sv
// window_sum_lane: one rotating accumulator of window_sum.
//   clk, reset - clock and asynchronous active-low reset (clears the accumulator)
//   en_i       - a sample is accepted this cycle
//   restart_i  - this lane starts a new partial sum with the current sample
//   d_i        - zero-extended sample
//   acc_o      - current accumulator value
module window_sum_lane
    import window_sum_pkg::*;
#(
    parameter int unsigned SUM_W = DefSumW
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en_i,
    input  logic             restart_i,
    input  logic [SUM_W-1:0] d_i,
    output logic [SUM_W-1:0] acc_o
);
    logic [SUM_W-1:0] acc_q, acc_d;

    always_comb begin
        acc_d = acc_q;
        if (en_i) begin
            acc_d = restart_i ? d_i : acc_q + d_i;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc_o = acc_q;
endmodule

// File: rtl/window_sum.sv
// window_sum: registered sum of the last WINDOW accepted samples.
//   clk   - single clock, rising edge
//   reset - asynchronous active-low reset
//   bus   - window_sum_if slave: clear / in_valid / d in, out_valid / sum_out out
// Lane k restarts when the phase is k and then collects every following sample, so
// at phase p lane (p+1) mod WINDOW holds the WINDOW-1 samples before the current one.
module window_sum
    import window_sum_pkg::*;
#(
    parameter int unsigned DATA_W = DefDataW,
    parameter int unsigned WINDOW = DefWindow
) (
    input  logic        clk,
    input  logic        reset,
    window_sum_if.slave bus
);
    localparam int unsigned SUM_W = sum_w(DATA_W, WINDOW);
    localparam int unsigned PW    = clog2(WINDOW);
    localparam int unsigned FW    = clog2(WINDOW + 1);
    localparam logic [PW-1:0] LastP = PW'(WINDOW - 1);
    localparam logic [FW-1:0] FullF = FW'(WINDOW);

    logic [PW-1:0]     p_q, p_d, p_eff, p_inc;
    logic [FW-1:0]     fill_q, fill_d, fill_eff, fill_inc;
    logic              valid_q, valid_d;
    logic [SUM_W-1:0]  sum_q, sum_d;
    logic [SUM_W-1:0]  d_ext;
    logic [WINDOW-1:0] lane_restart;
    logic [SUM_W-1:0]  acc [WINDOW];

    assign d_ext = SUM_W'(bus.d);

    for (genvar j = 0; j < WINDOW; j++) begin : g_lane
        assign lane_restart[j] = (p_eff == PW'(j));

        window_sum_lane #(
            .SUM_W (SUM_W)
        ) u_lane (
            .clk       (clk),
            .reset     (reset),
            .en_i      (bus.in_valid),
            .restart_i (lane_restart[j]),
            .d_i       (d_ext),
            .acc_o     (acc[j])
        );
    end

    always_comb begin
        // clear restarts the fill in the same cycle, so a sample arriving with it
        // lands in lane 0 as the first sample of the new window.
        p_eff    = bus.clear ? '0 : p_q;
        fill_eff = bus.clear ? '0 : fill_q;
        p_inc    = (p_eff == LastP) ? '0 : p_eff + PW'(1);
        fill_inc = (fill_eff == FullF) ? FullF : fill_eff + FW'(1);

        p_d     = p_eff;
        fill_d  = fill_eff;
        valid_d = 1'b0;
        sum_d   = sum_q;

        if (bus.in_valid) begin
            p_d    = p_inc;
            fill_d = fill_inc;
            // sum_out only moves on a complete window so it stays stable while filling.
            if (!bus.clear && (fill_inc == FullF)) begin
                valid_d = 1'b1;
                sum_d   = acc[p_inc] + d_ext;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            p_q     <= '0;
            fill_q  <= '0;
            valid_q <= 1'b0;
            sum_q   <= '0;
        end else begin
            p_q     <= p_d;
            fill_q  <= fill_d;
            valid_q <= valid_d;
            sum_q   <= sum_d;
        end
    end

    assign bus.out_valid = valid_q;
    assign bus.sum_out   = sum_q;
endmodule

// File: tb/tb_window_sum.sv
// Bench for window_sum: five instances (WINDOW 2,3,4,5,16, DATA_W 8) share one stimulus
// stream; a history-based reference model pushes expected sums to a scoreboard queue.
module tb_window_sum;
    import window_sum_pkg::*;

    localparam int NI = 5;
    localparam int WINS [NI] = '{2, 3, 4, 5, 16};

    logic       clk;
    logic       rst_n;
    logic       clear;
    logic       in_valid;
    logic [7:0] d;

    logic        dut_v [NI];
    logic [11:0] dut_s [NI];

    for (genvar gi = 0; gi < NI; gi++) begin : g_dut
        localparam int unsigned W = WINS[gi];

        window_sum_if #(.DATA_W(8), .SUM_W(sum_w(8, W))) u_bus ();

        assign u_bus.clear    = clear;
        assign u_bus.in_valid = in_valid;
        assign u_bus.d        = d;
        assign dut_v[gi]      = u_bus.out_valid;
        assign dut_s[gi]      = 12'(u_bus.sum_out);

        window_sum #(
            .DATA_W (8),
            .WINDOW (W)
        ) u_dut (
            .clk   (clk),
            .reset (rst_n),
            .bus   (u_bus)
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int inst;
        int sum;
    } sb_t;

    typedef struct {
        bit         iv;
        bit         cl;
        logic [7:0] d;
        bit         ev;
        int         es;
    } vec_t;

    sb_t  sbq [$];
    int   hist [NI][16];
    int   fill [NI];
    int   m_sum [NI];
    bit   m_valid [NI];
    int   n_vec;
    int   n_bad;
    vec_t vecs [23];

    task automatic chk(input string name, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < NI; k++) begin
            fill[k]    = 0;
            m_sum[k]   = 0;
            m_valid[k] = 1'b0;
            for (int i = 0; i < 16; i++) hist[k][i] = 0;
        end
        sbq.delete();
    endtask

    task automatic model_step(input bit iv, input bit cl, input int dd);
        int s;
        for (int k = 0; k < NI; k++) begin
            m_valid[k] = 1'b0;
            if (cl) fill[k] = 0;
            if (iv) begin
                for (int i = 15; i > 0; i--) hist[k][i] = hist[k][i-1];
                hist[k][0] = dd;
                if (fill[k] < WINS[k]) fill[k]++;
                if (!cl && fill[k] == WINS[k]) begin
                    s = 0;
                    for (int i = 0; i < WINS[k]; i++) s += hist[k][i];
                    m_valid[k] = 1'b1;
                    m_sum[k]   = s;
                    sbq.push_back('{inst: k, sum: s});
                end
            end
        end
    endtask

    task automatic check_outputs();
        sb_t e;
        for (int k = 0; k < NI; k++) begin
            chk($sformatf("valid_w%0d", WINS[k]), int'(dut_v[k]), int'(m_valid[k]));
            chk($sformatf("sum_w%0d", WINS[k]), int'(dut_s[k]), m_sum[k]);
            if (dut_v[k] === 1'b1) begin
                n_vec++;
                if (sbq.size() == 0 || sbq[0].inst != k) begin
                    n_bad++;
                    $display("FAIL sb_w%0d: got unexpected sum %0d, expected no output",
                             WINS[k], dut_s[k]);
                end else begin
                    e = sbq.pop_front();
                    if (int'(dut_s[k]) != e.sum) begin
                        n_bad++;
                        $display("FAIL sb_w%0d: got %0d, expected %0d", WINS[k], dut_s[k], e.sum);
                    end
                end
            end
        end
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            n_vec++;
            n_bad++;
            $display("FAIL sb_missing_w%0d: got no output, expected sum %0d", WINS[e.inst], e.sum);
        end
    endtask

    // Drive one cycle of stimulus, advance the model, and check after the edge.
    task automatic step(input bit iv, input bit cl, input int dd);
        in_valid = iv;
        clear    = cl;
        d        = 8'(dd);
        if (rst_n) model_step(iv, cl, dd);
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        clear    = 1'b0;
        rst_n    = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        check_outputs();
        rst_n = 1'b1;
    endtask

    initial begin
        n_vec    = 0;
        n_bad    = 0;
        rst_n    = 1'b0;
        clear    = 1'b0;
        in_valid = 1'b0;
        d        = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_outputs();
        rst_n = 1'b1;

        // WINDOW=3 hand-derived vectors: ramp, gapped fill, clear with and without data.
        vecs[0]  = '{1'b1, 1'b0, 8'd1, 1'b0, 0};
        vecs[1]  = '{1'b1, 1'b0, 8'd2, 1'b0, 0};
        vecs[2]  = '{1'b1, 1'b0, 8'd3, 1'b1, 6};
        vecs[3]  = '{1'b1, 1'b0, 8'd4, 1'b1, 9};
        vecs[4]  = '{1'b1, 1'b0, 8'd5, 1'b1, 12};
        vecs[5]  = '{1'b0, 1'b1, 8'd0, 1'b0, 12};
        vecs[6]  = '{1'b1, 1'b0, 8'd1, 1'b0, 12};
        vecs[7]  = '{1'b0, 1'b0, 8'd0, 1'b0, 12};
        vecs[8]  = '{1'b1, 1'b0, 8'd2, 1'b0, 12};
        vecs[9]  = '{1'b0, 1'b0, 8'd0, 1'b0, 12};
        vecs[10] = '{1'b0, 1'b0, 8'd0, 1'b0, 12};
        vecs[11] = '{1'b1, 1'b0, 8'd3, 1'b1, 6};
        vecs[12] = '{1'b1, 1'b0, 8'd4, 1'b1, 9};
        vecs[13] = '{1'b0, 1'b0, 8'd0, 1'b0, 9};
        vecs[14] = '{1'b0, 1'b1, 8'd0, 1'b0, 9};
        vecs[15] = '{1'b1, 1'b0, 8'd5, 1'b0, 9};
        vecs[16] = '{1'b1, 1'b0, 8'd6, 1'b0, 9};
        vecs[17] = '{1'b1, 1'b0, 8'd7, 1'b1, 18};
        vecs[18] = '{1'b1, 1'b0, 8'd8, 1'b1, 21};
        vecs[19] = '{1'b1, 1'b1, 8'd1, 1'b0, 21};
        vecs[20] = '{1'b1, 1'b0, 8'd2, 1'b0, 21};
        vecs[21] = '{1'b1, 1'b0, 8'd3, 1'b1, 6};
        vecs[22] = '{1'b1, 1'b0, 8'd4, 1'b1, 9};

        for (int i = 0; i < 23; i++) begin
            step(vecs[i].iv, vecs[i].cl, int'(vecs[i].d));
            chk($sformatf("vec%0d_valid_w3", i), int'(dut_v[1]), int'(vecs[i].ev));
            chk($sformatf("vec%0d_sum_w3", i), int'(dut_s[1]), vecs[i].es);
        end

        // WINDOW=4 full-scale samples: 4*255 must not wrap in 10 bits.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b0, 255);
            chk($sformatf("fullscale%0d_valid_w4", i), int'(dut_v[2]), (i >= 3) ? 1 : 0);
            if (i >= 3) chk($sformatf("fullscale%0d_sum_w4", i), int'(dut_s[2]), 1020);
        end

        // WINDOW=2 asynchronous reset between edges, samples ignored while held.
        do_reset();
        step(1'b1, 1'b0, 9);
        step(1'b1, 1'b0, 9);
        chk("pre_reset_sum_w2", int'(dut_s[0]), 18);
        #3;
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < NI; k++) begin
            chk($sformatf("async_valid_w%0d", WINS[k]), int'(dut_v[k]), 0);
            chk($sformatf("async_sum_w%0d", WINS[k]), int'(dut_s[k]), 0);
        end
        model_reset();
        step(1'b1, 1'b0, 77);
        step(1'b1, 1'b0, 77);
        in_valid = 1'b0;
        rst_n    = 1'b1;
        step(1'b1, 1'b0, 1);
        chk("post_reset1_valid_w2", int'(dut_v[0]), 0);
        step(1'b1, 1'b0, 2);
        chk("post_reset2_valid_w2", int'(dut_v[0]), 1);
        chk("post_reset2_sum_w2", int'(dut_s[0]), 3);
        step(1'b0, 1'b0, 0);
        chk("post_reset_gap_valid_w2", int'(dut_v[0]), 0);

        // Random valid / clear / data against the reference model on all instances.
        do_reset();
        for (int i = 0; i < 800; i++) begin
            bit iv;
            bit cl;
            int dd;
            iv = ($urandom_range(0, 3) != 0);
            cl = ($urandom_range(0, 29) == 0);
            dd = ($urandom_range(0, 7) == 0) ? 255 : int'($urandom_range(0, 255));
            step(iv, cl, dd);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
